// File: rtl/chain_meter_pkg.sv
// ============================================================================
// Module      : chain_meter_pkg
// Description : Shared FSM state encoding and counter defaults for chain_delay_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chain_meter_pkg;

    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_IDLE    = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam int unsigned                 DEF_CNT_WIDTH = 16;
    localparam logic [DEF_CNT_WIDTH-1:0]    DEF_CNT_SAT   = {DEF_CNT_WIDTH{1'b1}};

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module      : sync_ff
// Description : N-stage synchronizer, asynchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/chain_delay_meter.sv
// ============================================================================
// Module      : chain_delay_meter
// Description : Launches a transition into an inverter chain and counts clock
//               cycles until the synchronized chain output changes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chain_delay_meter
    import chain_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLDOFF_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 chain_in,
    input  logic                 chain_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 timeout,
    output logic                 edge_dir
);

    localparam int unsigned          HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0]      HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [HO_W-1:0]      ho_q, ho_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] result_q, result_d;
    logic                 chain_in_q, chain_in_d;
    logic                 baseline_q, baseline_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 edge_dir_q, edge_dir_d;
    logic                 out_sync;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_out (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (chain_out),
        .q     (out_sync)
    );

    always_comb begin
        state_d    = state_q;
        ho_d       = ho_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        chain_in_d = chain_in_q;
        baseline_d = baseline_q;
        timeout_d  = timeout_q;
        edge_dir_d = edge_dir_q;
        done_d     = 1'b0;

        case (state_q)
            ST_HOLDOFF: begin
                if (ho_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ho_d = ho_q - HO_W'(1);
                end
            end
            ST_IDLE: begin
                if (start) begin
                    chain_in_d = ~chain_in_q;
                    edge_dir_d = ~chain_in_q;
                    baseline_d = out_sync;
                    cnt_d      = '0;
                    state_d    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Any change counts, so chain polarity (odd/even length) is irrelevant.
                if (out_sync != baseline_q) begin
                    result_d  = cnt_q;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_HOLDOFF;
                    ho_d      = HO_LOAD;
                end else if (cnt_q == CNT_SAT) begin
                    result_d  = CNT_SAT;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_HOLDOFF;
                    ho_d      = HO_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_HOLDOFF;
                ho_d    = HO_LOAD;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLDOFF;
            ho_q       <= HO_LOAD;
            cnt_q      <= '0;
            result_q   <= '0;
            chain_in_q <= 1'b0;
            baseline_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            edge_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ho_q       <= ho_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            chain_in_q <= chain_in_d;
            baseline_q <= baseline_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            edge_dir_q <= edge_dir_d;
        end
    end

    assign chain_in = chain_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign timeout  = timeout_q;
    assign edge_dir = edge_dir_q;

endmodule

`default_nettype wire

// File: tb/tb_chain_delay_meter.sv
// ============================================================================
// Module      : tb_chain_delay_meter
// Description : Scoreboard bench for chain_delay_meter with a modelled delay chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chain_delay_meter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic        chain_in, chain_out, busy, done, timeout, edge_dir;
    logic [15:0] result;
    logic        chain_in2, busy2, done2, timeout2, edge_dir2;
    logic [3:0]  result2;

    always #5 clk = ~clk;

    // Chain model: dly registered stages (0 = purely combinational), optional inversion.
    int          dly;
    logic        inv;
    logic [31:0] dl;
    always @(posedge clk) dl <= {dl[30:0], chain_in};
    always_comb chain_out = ((dly == 0) ? chain_in : dl[dly-1]) ^ inv;

    chain_delay_meter #(.CNT_WIDTH(16), .SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chain_in(chain_in), .chain_out(chain_out),
        .busy(busy), .done(done), .result(result), .timeout(timeout), .edge_dir(edge_dir)
    );

    chain_delay_meter #(.CNT_WIDTH(4), .SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .chain_in(chain_in2), .chain_out(1'b0),
        .busy(busy2), .done(done2), .result(result2), .timeout(timeout2), .edge_dir(edge_dir2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res;
        logic        tmo;
        logic        dir;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic model_dir;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding measurement.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending measurement at %0t", $time);
            end else begin
                e = q.pop_front();
                check("result", {16'd0, result}, {16'd0, e.res});
                check("timeout", {31'd0, timeout}, {31'd0, e.tmo});
                check("edge_dir", {31'd0, edge_dir}, {31'd0, e.dir});
            end
        end
        prev_done <= done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=%b expected 0 within 300 cycles", busy);
        end
    endtask

    task automatic pulse_start();
        wait_idle();
        start = 1'b1;
        model_dir = ~model_dir;
        q.push_back('{res: 16'(dly + SYNC), tmo: 1'b0, dir: model_dir});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("chain_in_launch", {31'd0, chain_in}, {31'd0, model_dir});
        check("busy_measure", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_chain_in"}, {31'd0, chain_in}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_result"}, {16'd0, result}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_edge_dir"}, {31'd0, edge_dir}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        dly = 5;
        inv = 1'b0;
        dl = '0;
        model_dir = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        start = 1'b1;

        // Hold-off after reset: start is ignored, busy high for exactly 8 cycles.
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check("holdoff_busy", {31'd0, busy}, (i < 8) ? 32'd1 : 32'd0);
            check("holdoff_chain_in", {31'd0, chain_in}, 32'd0);
            check("holdoff_result", {16'd0, result}, 32'd0);
            if (i == 7) start = 1'b0;
        end

        pulse_start();
        pulse_start();
        wait_idle();
        repeat (32) @(posedge clk);
        #1;
        dly = 0;
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        wait_idle();

        // Saturation on the 4-bit instance with a constant chain output.
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_done_latency", n, 32'd16);
        check("sat_result", {28'd0, result2}, 32'd15);
        check("sat_timeout", {31'd0, timeout2}, 32'd1);
        check("sat_edge_dir", {31'd0, edge_dir2}, 32'd1);

        for (int r = 0; r < 10; r++) begin
            wait_idle();
            repeat (32) @(posedge clk);
            #1;
            dly = int'($urandom_range(0, 20));
            inv = 1'($urandom_range(0, 1));
            repeat (4) @(posedge clk);
            #1;
            pulse_start();
        end

        // Abort a measurement with reset three cycles in.
        wait_idle();
        repeat (32) @(posedge clk);
        #1;
        dly = 10;
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        model_dir = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        pulse_start();
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        check("pending_measurements", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
